// File: rtl/axi_aw_w_arbiter_pkg.sv
// axi_arb_pkg: shared types and round-robin helper for the AW/W write-path arbiter
package axi_arb_pkg;
  localparam int MAX_PORTS = 32;
  localparam int MAX_IDX_W = $clog2(MAX_PORTS);
  typedef enum logic {IDLE, LOCKED} arb_state_e;
  typedef logic [MAX_IDX_W-1:0] idx_t;
  function automatic int rr_first(input logic [MAX_PORTS-1:0] req, input idx_t ptr, input int n);
    int sel;
    logic hit;
    sel = int'(ptr);
    hit = 1'b0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      int j;
      j = (int'(ptr) + i) % n;
      if (!hit && i < n && req[j]) begin
        sel = j;
        hit = 1'b1;
      end
    end
    return sel;
  endfunction
endpackage

// File: rtl/axi_aw_w_arbiter_if.sv
// axi_aw_w_arbiter_if: upstream AW/W ports and downstream AW/W port of the arbiter
//   slave modport: the arbiter's view; master modport: the surrounding fabric's view
interface axi_aw_w_arbiter_if #(
  parameter int NUM_SLV = 4,
  parameter int ID_W    = 4,
  parameter int AW_W    = 64,
  parameter int W_W     = 73,
  parameter int IDX_W   = $clog2(NUM_SLV)
);
  logic [NUM_SLV-1:0]           slv_aw_valid_i, slv_aw_ready_o;
  logic [NUM_SLV-1:0][ID_W-1:0] slv_aw_id_i;
  logic [NUM_SLV-1:0][3:0]      slv_aw_qos_i;
  logic [NUM_SLV-1:0][AW_W-1:0] slv_aw_chan_i;
  logic [NUM_SLV-1:0]           slv_w_valid_i, slv_w_ready_o, slv_w_last_i;
  logic [NUM_SLV-1:0][W_W-1:0]  slv_w_chan_i;
  logic                         mst_aw_valid_o, mst_aw_ready_i;
  logic [IDX_W+ID_W-1:0]        mst_aw_id_o;
  logic [3:0]                   mst_aw_qos_o;
  logic [AW_W-1:0]              mst_aw_chan_o;
  logic                         mst_w_valid_o, mst_w_ready_i, mst_w_last_o;
  logic [W_W-1:0]               mst_w_chan_o;
  modport slave (
    input  slv_aw_valid_i, slv_aw_id_i, slv_aw_qos_i, slv_aw_chan_i,
    input  slv_w_valid_i, slv_w_last_i, slv_w_chan_i, mst_aw_ready_i, mst_w_ready_i,
    output slv_aw_ready_o, slv_w_ready_o, mst_aw_valid_o, mst_aw_id_o, mst_aw_qos_o,
    output mst_aw_chan_o, mst_w_valid_o, mst_w_last_o, mst_w_chan_o
  );
  modport master (
    output slv_aw_valid_i, slv_aw_id_i, slv_aw_qos_i, slv_aw_chan_i,
    output slv_w_valid_i, slv_w_last_i, slv_w_chan_i, mst_aw_ready_i, mst_w_ready_i,
    input  slv_aw_ready_o, slv_w_ready_o, mst_aw_valid_o, mst_aw_id_o, mst_aw_qos_o,
    input  mst_aw_chan_o, mst_w_valid_o, mst_w_last_o, mst_w_chan_o
  );
endinterface

// File: rtl/axi_aw_w_arbiter_ord_fifo.sv
// axi_arb_ord_fifo: AW grant order FIFO (push idx on AW handshake, pop on WLAST)
//   clk_i/rst_ni clock and sync active-low reset; push_i/data_i write; pop_i/data_o head;
//   full_o/empty_o flags
module axi_arb_ord_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW:0] wr_q, rd_q;
  assign empty_o = wr_q == rd_q;
  assign full_o  = wr_q == {~rd_q[PW], rd_q[PW-1:0]};
  assign data_o  = mem_q[rd_q[PW-1:0]];
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i && !full_o) begin
        mem_q[wr_q[PW-1:0]] <= data_i;
        wr_q <= wr_q + 1'b1;
      end
      if (pop_i && !empty_o) rd_q <= rd_q + 1'b1;
    end
  end
endmodule

// File: rtl/axi_aw_w_arbiter.sv
// axi_aw_w_arbiter: merges NUM_SLV upstream AW/W channels onto one downstream port
//   clk_i/rst_ni clock and sync active-low reset; bus: AW/W handshakes and payloads
//   (axi_aw_w_arbiter_if.slave); ord_full_o order FIFO full status.
//   AXI_AW_QOS_ARB_EN: restrict idle arbitration to the highest-QoS requesters.
module axi_aw_w_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_SLV   = 4,
  parameter int ID_W      = 4,
  parameter int AW_W      = 64,
  parameter int W_W       = 73,
  parameter int ORD_DEPTH = 4,
  parameter int IDX_W     = $clog2(NUM_SLV)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  axi_aw_w_arbiter_if.slave bus,
  output logic              ord_full_o
);
  arb_state_e state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d, gnt_q, gnt_d, gnt, head;
  logic [NUM_SLV-1:0] elig;
  logic ord_empty, aw_hs, w_pop;
`ifdef AXI_AW_QOS_ARB_EN
  logic [3:0] max_qos;
  always_comb begin
    max_qos = '0;
    elig = '0;
    for (int i = 0; i < NUM_SLV; i++)
      max_qos = (bus.slv_aw_valid_i[i] && bus.slv_aw_qos_i[i] > max_qos) ? bus.slv_aw_qos_i[i] : max_qos;
    for (int i = 0; i < NUM_SLV; i++)
      elig[i] = bus.slv_aw_valid_i[i] && bus.slv_aw_qos_i[i] == max_qos;
  end
`else
  assign elig = bus.slv_aw_valid_i;
`endif
  // while locked the grant is frozen so the presented AW stays stable until accepted
  assign gnt = state_q == LOCKED ? gnt_q
             : IDX_W'(rr_first(MAX_PORTS'(elig), idx_t'(rr_ptr_q), NUM_SLV));
  assign bus.mst_aw_valid_o = !ord_full_o && (state_q == LOCKED ? bus.slv_aw_valid_i[gnt_q] : |elig);
  assign bus.mst_aw_id_o    = {gnt, bus.slv_aw_id_i[gnt]};
  assign bus.mst_aw_qos_o   = bus.slv_aw_qos_i[gnt];
  assign bus.mst_aw_chan_o  = bus.slv_aw_chan_i[gnt];
  assign aw_hs = bus.mst_aw_valid_o && bus.mst_aw_ready_i;
  always_comb begin
    bus.slv_aw_ready_o = '0;
    bus.slv_aw_ready_o[gnt] = bus.mst_aw_valid_o && bus.mst_aw_ready_i;
  end
  always_comb begin
    state_d  = aw_hs ? IDLE : bus.mst_aw_valid_o ? LOCKED : state_q;
    gnt_d    = (!aw_hs && bus.mst_aw_valid_o) ? gnt : gnt_q;
    rr_ptr_d = !aw_hs ? rr_ptr_q : gnt == IDX_W'(NUM_SLV - 1) ? '0 : gnt + 1'b1;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
    end
  end
  // W beats carry no ID: only the port at the head of the grant order may talk
  assign bus.mst_w_valid_o = !ord_empty && bus.slv_w_valid_i[head];
  assign bus.mst_w_last_o  = bus.slv_w_last_i[head];
  assign bus.mst_w_chan_o  = bus.slv_w_chan_i[head];
  assign w_pop = bus.mst_w_valid_o && bus.mst_w_ready_i && bus.mst_w_last_o;
  always_comb begin
    bus.slv_w_ready_o = '0;
    bus.slv_w_ready_o[head] = !ord_empty && bus.mst_w_ready_i;
  end
  axi_arb_ord_fifo #(.DEPTH(ORD_DEPTH), .WIDTH(IDX_W)) u_ord (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (aw_hs),
    .data_i  (gnt),
    .pop_i   (w_pop),
    .data_o  (head),
    .full_o  (ord_full_o),
    .empty_o (ord_empty)
  );
endmodule
